alu_issue: RTL and testbench

Operand issue and result staging stage wrapped around the packed 4-lane adder ALU. Accepts add operations (two 32-bit operands, lane width, saturate flag) over a valid/ready handshake, buffers them in a small FIFO, and presents the FIFO head to the ALU. It registers the ALU result and returns it over a second valid/ready handshake. Gives the combinational ALU a registered, back-pressurable pipeline boundary on both sides.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_op_fifo.sv | 67 ++++++
 rtl/alu_issue.sv | 116 +++++++++++
 tb/tb_alu_issue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the packed-lane adder ALU and its issue stage.
//   W8/W16/W32/WRSV : lane width encodings carried on the width field
//   alu_op_t        : one queued operation {a, b, width, sat}, 67 bits
package alu_pkg;

    localparam logic [1:0] W8   = 2'b00;
    localparam logic [1:0] W16  = 2'b01;
    localparam logic [1:0] W32  = 2'b10;
    localparam logic [1:0] WRSV = 2'b11;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  width;
        logic        sat;
    } alu_op_t;

    localparam int ALU_OP_W = $bits(alu_op_t);

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO of alu_op_t entries.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_op      write i_op at the tail (ignored when full)
//   i_pop             drop the head entry (ignored when empty)
//   o_head            entry at the head; meaningful only while o_count != 0
//   o_count           occupancy, 0..DEPTH
// Storage is not reset; only pointers and occupancy are.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  alu_op_t                  i_op,
    input  logic                     i_pop,
    output alu_op_t                  o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_op_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push && (r_count != FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_op;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue.sv
// Operand issue and result staging around the packed 4-lane adder ALU.
// Operations enter over in_valid/in_ready into a DEPTH-entry FIFO; the FIFO
// head drives alu_*; the ALU result is captured into out_c and returned over
// out_valid/out_ready.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  operation handshake
//   in_a, in_b, in_width, in_sat       operation fields
//   alu_a, alu_b, alu_width, alu_sat   to the external ALU
//   alu_c                              ALU result (combinational from alu_*)
//   out_valid/out_ready, out_c         result handshake and registered result
//   count                              FIFO occupancy
// Optional feature: ALU_ISSUE_BYPASS_EN -- when the FIFO is empty and the
// result register can load, an offered op goes straight to the ALU and its
// result is captured at the accepting edge (1-edge latency).
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [1:0]               in_width,
    input  logic                     in_sat,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [1:0]               alu_width,
    output logic                     alu_sat,
    input  logic [31:0]              alu_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_op_t         w_in_op;
    alu_op_t         w_head;
    alu_op_t         w_alu_op;
    logic [CW-1:0]   w_count;
    logic            w_head_valid;
    logic            w_can_load;
    logic            w_issue;
    logic            w_bypass;
    logic            w_push;
    logic            w_load;
    logic            r_out_valid;
    logic [31:0]     r_out_c;

    assign w_in_op = '{a: in_a, b: in_b, width: in_width, sat: in_sat};

    assign w_head_valid = (w_count != '0);
    assign w_can_load   = !r_out_valid || out_ready;
    assign w_issue      = w_head_valid && w_can_load;
    assign in_ready     = (w_count != FULL);

`ifdef ALU_ISSUE_BYPASS_EN
    // Empty FIFO implies in_ready, so a bypassed op is always accepted.
    assign w_bypass = !w_head_valid && in_valid && w_can_load;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && in_ready && !w_bypass;
    assign w_load = w_issue || w_bypass;

    alu_op_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_op    (w_in_op),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Zero when idle so the ALU inputs never show stale FIFO storage.
    always_comb begin
        w_alu_op = '0;
        if (w_head_valid) begin
            w_alu_op = w_head;
        end else if (w_bypass) begin
            w_alu_op = w_in_op;
        end
    end

    assign alu_a     = w_alu_op.a;
    assign alu_b     = w_alu_op.b;
    assign alu_width = w_alu_op.width;
    assign alu_sat   = w_alu_op.sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_c     <= alu_c;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign count     = w_count;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    localparam int DEPTH = 4;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_width = '0;
    logic        in_sat = 1'b0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [1:0]  alu_width;
    logic        alu_sat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_width  (in_width),
        .in_sat    (in_sat),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_width (alu_width),
        .alu_sat   (alu_sat),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .count     (count)
    );

    // Lane-wise adder: width selects 8/16/32-bit lanes (reserved code adds
    // as a single 32-bit lane); sat clamps each lane at its unsigned maximum.
    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                           logic [1:0] w, logic s);
        int lw;
        longint unsigned mask, la, lb, sum, res;
        lw  = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
        mask = (64'd1 << lw) - 64'd1;
        res = 0;
        for (int base = 0; base < 32; base += lw) begin
            la  = (longint'(a) >> base) & mask;
            lb  = (longint'(b) >> base) & mask;
            sum = la + lb;
            if (s && sum > mask) sum = mask;
            res = res | ((sum & mask) << base);
        end
        return res[31:0];
    endfunction

    always_comb alu_c = alu_fn(alu_a, alu_b, alu_width, alu_sat);

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted op yields alu_fn(op), returned in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back(alu_fn(in_a, in_b, in_width, in_sat));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("out_unexpected", out_c, 32'hxxxx_xxxx);
                else chk("out_order", out_c, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(logic [31:0] a, logic [31:0] b, logic [1:0] w, logic s);
        bit ok = 0;
        in_a = a; in_b = b; in_width = w; in_sat = s; in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (count == 0) && !out_valid && (exp_q.size() == 0);
            @(posedge clk); #1;
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  w;
        logic        s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] held;
        int base_out, sent;
        logic [31:0] ra, rb;
        logic [1:0]  rw;
        logic        rs;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 2'b10, 1'b0, 32'h0000_0003};
        vecs[1] = '{32'h01FF_01FF, 32'h0101_0101, 2'b00, 1'b0, 32'h0200_0200};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 1'b1, 32'hFFFF_FFFF};
        vecs[4] = '{32'h80FF_7F00, 32'h8002_0001, 2'b00, 1'b1, 32'hFFFF_7F01};
        vecs[5] = '{32'h0001_FFFF, 32'h0001_0001, 2'b01, 1'b0, 32'h0002_0000};
        vecs[6] = '{32'h0001_FFFF, 32'h0001_0001, 2'b01, 1'b1, 32'h0002_FFFF};
        vecs[7] = '{32'h0000_0010, 32'h0000_0020, 2'b11, 1'b0, 32'h0000_0030};

        // Reset state
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c", out_c, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ops: latency and value
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_a = vecs[i].a; in_b = vecs[i].b;
            in_width = vecs[i].w; in_sat = vecs[i].s; in_valid = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                chk("vec_latency", 32'(out_valid), 32'(k == LAT));
                if (k == LAT) chk("vec_value", out_c, vecs[i].exp);
`ifndef ALU_ISSUE_BYPASS_EN
                if (k == 1) chk("vec_alu_a", alu_a, vecs[i].a);
`endif
                @(posedge clk); #1;
            end
        end
        wait_idle();

        // Back-pressure: 5 ops with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_op(32'h100 * (i + 1), 32'(i), 2'b10, 1'b0);
        @(negedge clk);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_first", out_c, 32'h100);
        held = out_c;
        repeat (3) @(negedge clk);
        chk("bp_hold", out_c, held);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_drain_rate", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Simultaneous push/pop holding count at 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_op(32'h1000 + 32'(i), 32'h10, 2'b01, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 32'($urandom); in_b = 32'($urandom);
            in_width = 2'($urandom_range(0, 2)); in_sat = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            chk("pp_count", 32'(count), 32'd2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Pointer wrap with random back-pressure
        base_out = n_out;
        sent = 0;
        ra = 32'($urandom); rb = 32'($urandom);
        rw = 2'($urandom_range(0, 3)); rs = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 2000 && (sent < 3 * DEPTH || exp_q.size() != 0 || out_valid); cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 3 * DEPTH) begin
                in_a = ra; in_b = rb; in_width = rw; in_sat = rs;
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                ra = 32'($urandom); rb = 32'($urandom);
                rw = 2'($urandom_range(0, 3)); rs = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("wrap_sent", 32'(sent), 32'(3 * DEPTH));
        chk("wrap_received", 32'(n_out - base_out), 32'(3 * DEPTH));
        out_ready = 1'b1;
        wait_idle();

        // Asynchronous reset with entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_op(32'hDEAD_0000 + 32'(i), 32'h1, 2'b10, 1'b0);
        @(negedge clk);
        chk("rstmid_count_pre", 32'(count), 32'd3);
        chk("rstmid_valid_pre", 32'(out_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_out_c", out_c, 32'd0);
        chk("rstmid_alu_b", alu_b, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_op(32'h0000_0005, 32'h0000_0007, 2'b10, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("rstmid_new_latency", 32'(out_valid), 32'(k == LAT));
            if (k == LAT) chk("rstmid_new_value", out_c, 32'h0000_000C);
            @(posedge clk); #1;
        end
        repeat (4) @(negedge clk);
        chk("rstmid_no_stale", 32'(out_valid), 32'd0);
        chk("rstmid_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
